// File: rtl/i3c_bus_monitor.sv
// I3C bus-condition monitor: registered SCL/SDA levels, edge pulses and
// setup/hold-qualified START, Repeated START and STOP detection.
module i3c_bus_monitor #(
  parameter int unsigned TimerW = 20
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              scl_i,
  input  logic              sda_i,
  input  logic [TimerW-1:0] t_su_sta_i,
  input  logic [TimerW-1:0] t_hd_sta_i,
  input  logic [TimerW-1:0] t_su_sto_i,
  input  logic [TimerW-1:0] t_hd_sto_i,
  output logic              scl_high_o,
  output logic              scl_low_o,
  output logic              sda_high_o,
  output logic              sda_low_o,
  output logic              scl_posedge_o,
  output logic              scl_negedge_o,
  output logic              sda_posedge_o,
  output logic              sda_negedge_o,
  output logic              start_detected_o,
  output logic              stop_detected_o,
  output logic              bus_busy_o
);

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StStartHold = 2'd1,
    StStopHold  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              scl_q, scl_prev, sda_q, sda_prev;
  logic [TimerW-1:0] scl_high_cnt_q, scl_high_cnt_d;
  logic [TimerW-1:0] hold_cnt_q, hold_cnt_d;
  logic [TimerW-1:0] hold_inc;
  logic [TimerW-1:0] sta_thr, sto_thr;
  logic              start_cond, stop_cond;
  logic              start_pulse, stop_pulse;
  logic              bus_busy_q;

  // Two sample stages per line; idle bus level is high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_q    <= 1'b1;
      scl_prev <= 1'b1;
      sda_q    <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_q    <= scl_i;
      scl_prev <= scl_q;
      sda_q    <= sda_i;
      sda_prev <= sda_q;
    end
  end

  assign scl_high_o    = scl_q;
  assign scl_low_o     = ~scl_q;
  assign sda_high_o    = sda_q;
  assign sda_low_o     = ~sda_q;
  assign scl_posedge_o = scl_q & ~scl_prev;
  assign scl_negedge_o = ~scl_q & scl_prev;
  assign sda_posedge_o = sda_q & ~sda_prev;
  assign sda_negedge_o = ~sda_q & sda_prev;

  // Counts SCL-high cycles preceding the current one, saturating.
  always_comb begin
    scl_high_cnt_d = '0;
    if (scl_high_o) begin
      scl_high_cnt_d = (scl_high_cnt_q == '1) ? scl_high_cnt_q
                                              : scl_high_cnt_q + TimerW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_high_cnt_q <= '0;
    end else begin
      scl_high_cnt_q <= scl_high_cnt_d;
    end
  end

  assign sta_thr  = (t_hd_sta_i == '0) ? TimerW'(1) : t_hd_sta_i;
  assign sto_thr  = (t_hd_sto_i == '0) ? TimerW'(1) : t_hd_sto_i;
  assign hold_inc = hold_cnt_q + TimerW'(1);

  assign start_cond = sda_negedge_o & scl_high_o & (scl_high_cnt_q >= t_su_sta_i);
  assign stop_cond  = sda_posedge_o & scl_high_o & (scl_high_cnt_q >= t_su_sto_i);

  // New qualifying edges take priority over the hold in progress, which gives
  // Repeated START and START-hold-to-STOP without an intervening idle cycle.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    start_pulse = 1'b0;
    stop_pulse  = 1'b0;
    if (!enable_i) begin
      state_d    = StIdle;
      hold_cnt_d = '0;
    end else if (start_cond) begin
      state_d    = StStartHold;
      hold_cnt_d = '0;
    end else if (stop_cond) begin
      state_d    = StStopHold;
      hold_cnt_d = '0;
    end else begin
      unique case (state_q)
        StStartHold: begin
          if (scl_low_o || sda_high_o) begin
            state_d    = StIdle;
            hold_cnt_d = '0;
          end else if (hold_inc >= sta_thr) begin
            start_pulse = 1'b1;
            state_d     = StIdle;
            hold_cnt_d  = '0;
          end else begin
            hold_cnt_d = hold_inc;
          end
        end
        StStopHold: begin
          if (scl_low_o || sda_low_o) begin
            state_d    = StIdle;
            hold_cnt_d = '0;
          end else if (hold_inc >= sto_thr) begin
            stop_pulse = 1'b1;
            state_d    = StIdle;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_inc;
          end
        end
        default: begin
          state_d    = StIdle;
          hold_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      hold_cnt_q <= '0;
      bus_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      if (start_pulse) begin
        bus_busy_q <= 1'b1;
      end else if (stop_pulse) begin
        bus_busy_q <= 1'b0;
      end
    end
  end

  assign start_detected_o = start_pulse;
  assign stop_detected_o  = stop_pulse;
  assign bus_busy_o       = bus_busy_q;

endmodule
